// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction fetch stage for the RV64 single-cycle core. Keeps the fetch PC,
//   issues one 32-bit instruction read at a time over a valid/ready request
//   port, buffers returned words together with their PC in a small FIFO and
//   hands {inst_o, inst_pc_o} to the core over a valid/ready port. A redirect
//   flushes the buffer and restarts fetch; halt stops new requests.
//
// Ports
//   clk_i             clock, all state on rising edge
//   rst_ni            asynchronous reset, active low
//   imem_req_valid_o  read request valid
//   imem_req_ready_i  memory accepts request
//   imem_req_addr_o   read address (current fetch PC)
//   imem_rsp_valid_i  read data valid
//   imem_rsp_data_i   returned instruction word
//   redirect_valid_i  flush buffer and restart fetch at redirect_pc_i
//   redirect_pc_i     new fetch PC (low 2 bits forced to 0)
//   halt_i            level, blocks new requests
//   inst_valid_o      buffer head valid
//   inst_ready_i      core consumes head
//   inst_o            head instruction
//   inst_pc_o         head PC
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | no request outstanding, may issue
// S_WAIT      | one request outstanding, its response will be buffered
// S_WAIT_DROP | one request outstanding, its response will be discarded
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WAIT_DROP
  } state_e;

  state_e           state_q;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  req_pc_q;
  logic [31:0]      buf_inst_q [FIFO_DEPTH];
  logic [XLEN-1:0]  buf_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic req_hs;
  logic rsp_fire;
  logic push;
  logic pop;

  // Issue depends only on registers plus halt; redirect never reaches the
  // request port combinationally. The count gate guarantees a free slot for
  // the single outstanding response.
  assign imem_req_valid_o = rst_ni & (state_q == S_IDLE) & ~halt_i & (count_q < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc_q;

  assign req_hs   = imem_req_valid_o & imem_req_ready_i;
  assign rsp_fire = imem_rsp_valid_i & (state_q != S_IDLE);

  // A response landing in the redirect cycle belongs to the old stream.
  assign push = rsp_fire & (state_q == S_WAIT) & ~redirect_valid_i;
  assign pop  = inst_valid_o & inst_ready_i & ~redirect_valid_i;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = buf_inst_q[rd_ptr_q];
  assign inst_pc_o    = buf_pc_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (redirect_valid_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;

      if (push) begin
        buf_inst_q[wr_ptr_q] <= imem_rsp_data_i;
        buf_pc_q[wr_ptr_q]   <= req_pc_q;
      end

      if (req_hs) begin
        req_pc_q <= fetch_pc_q;
      end

      if (redirect_valid_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fetch_pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (req_hs) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      end

      case (state_q)
        S_IDLE: begin
          // A request accepted in the redirect cycle fetches a stale PC.
          if (req_hs) state_q <= redirect_valid_i ? S_WAIT_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (rsp_fire)              state_q <= S_IDLE;
          else if (redirect_valid_i) state_q <= S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          if (rsp_fire) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
